control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcode sequencer for the 8-bit computer. It sits directly upstream of the control-signal bundle and produces the 24-bit control word that the bundle distributes to the bus drivers and registers. A step counter walks each instruction through fetch (T0–T1) and execute (T2–T4). The word for each step is decoded from the opcode, the step and the ALU flags. Empty trailing steps are skipped, and a halt latch stops the machine.

## Interface
- No parameters; control-word bit positions are fixed: 0 HLT, 1 MI, 2 RI, 3 RO, 4 IO, 5 II, 6 RegI, 7 RegO, 8 EO, 9 SU, 10 BI, 11 OI, 12 CE, 13 CO, 14 J, 15 FI, 16–23 IOM/IIM/IOA/IIA/XI/SPJ/BPI/BPO.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  4  instruction register bits [7:4], valid from T2 onward.
- flags  input  2  registered ALU flags: [0] carry, [1] zero.
- control_word  output  24  microinstruction for the current step (combinational from registered state).
- step  output  3  current micro-step, 0–4.
- halted  output  1  halt latch.

## Operation
- Fetch, for all opcodes:
  - T0 = CO|MI (0x002002).
  - T1 = RO|II|CE (0x001028).
- Execute words; unlisted steps are 0:
  - 0 NOP: none.
  - 1 LDA: T2 IO|MI 0x000012; T3 RO|RegI 0x000048.
  - 2 ADD: T2 0x000012; T3 RO|BI 0x000408; T4 EO|RegI|FI 0x008140.
  - 3 SUB: as ADD, except T4 = 0x008340 (adds SU).
  - 4 STA: T2 0x000012; T3 RegO|RI 0x000084.
  - 5 LDI: T2 IO|RegI 0x000050.
  - 6 JMP: T2 IO|J 0x004010.
  - 7 JC: T2 0x004010 if flags[0], else 0.
  - 8 JZ: T2 0x004010 if flags[1], else 0.
  - 14 OUT: T2 RegO|OI 0x000880.
  - 15 HLT: T2 HLT 0x000001.
  - 9–13: treated as NOP.
- Bits 16–23 are driven 0 in this revision.
- Step sequencing:
  - From step 0: next step is 1.
  - From step 1: next step is 2, unconditionally. The opcode is not yet valid during T1.
  - From step s ≥ 2: next step is 0 if s = 4 or the decoded word for s+1 is 0; otherwise s+1.
  - Lookahead uses the current opcode and flags.
- Halt:
  - A HLT bit in the current word sets halted at the next edge; step goes to 0 on that edge.
  - While halted: step is frozen at 0 and control_word = 0.
  - Only rst clears halted.
- Reset: step = 0, halted = 0. control_word is forced to 0 during any cycle in which rst is high.

## Timing
- Instruction lengths, T0 through the last step:
  - 3 cycles: NOP, LDI, JMP, OUT, untaken JC/JZ. The NOP-class opcodes spend an all-zero T2.
  - 3 cycles: taken JC/JZ.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.
- HLT: T0, T1, T2 = 0x000001. halted = 1 from the following cycle.
- Downstream consumers latch on the rising edge that ends the cycle in which control_word is presented.
- Flags are sampled combinationally in T2. A flag change in the same cycle therefore affects the JC/JZ decision immediately.
- rst asserted mid-instruction: on the next edge step = 0 and halted = 0, and the partial instruction is abandoned. The first cycle after rst deasserts presents 0x002002.
- rst and a HLT word in the same cycle: reset wins, halted stays 0.

## Test plan
- Reset, then opcode = 1 (LDA) held: words 0x002002, 0x001028, 0x000012, 0x000048, then 0x002002. step sequence 0,1,2,3,0.
- opcode = 3 (SUB): T2–T4 = 0x000012, 0x000408, 0x008340; step reaches 4 and wraps to 0.
- opcode = 7 (JC):
  - flags = 2'b00: T2 = 0, step returns to 0 after 3 cycles.
  - flags = 2'b01: T2 = 0x004010.
  - Repeat for JZ with flags = 2'b10.
- opcode = 15 (HLT): T2 = 0x000001. Afterwards halted = 1, step = 0 and control_word = 0 for 10+ cycles while opcode is changed. rst clears halted, and the next word is 0x002002.
- rst pulsed during T3 of ADD: next cycle step = 0 and control_word = 0 while rst is high. After release, the sequence restarts at 0x002002.
- Opcodes 9–13 and 0: each yields 3-cycle instructions with an all-zero T2. Bits 16–23 are never set across any opcode/flag combination.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Bundle between the microcode sequencer and the instruction/flag sources
// and control-word consumers.
//   opcode        IR[7:4], valid from T2 onward
//   flags         registered ALU flags: [0] carry, [1] zero
//   control_word  24-bit microinstruction for the current step
//   step          current micro-step (0-4)
//   halted        halt latch
// master: the sequencer side; slave: the datapath side.
interface control_sequencer_if;
   logic [3:0]  opcode;
   logic [1:0]  flags;
   logic [23:0] control_word;
   logic [2:0]  step;
   logic        halted;

   modport master (
      input  opcode,
      input  flags,
      output control_word,
      output step,
      output halted
   );

   modport slave (
      output opcode,
      output flags,
      input  control_word,
      input  step,
      input  halted
   );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit computer. Walks each instruction through
// fetch (T0-T1) and execute (T2-T4), decoding a 24-bit control word from
// opcode, step and ALU flags. Trailing all-zero steps are skipped and a HLT
// word latches the machine until reset.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  control_sequencer_if.master (opcode, flags in; control_word, step,
//        halted out)
//
// state | meaning
// T0    | fetch: PC onto bus, load MAR
// T1    | fetch: RAM into IR, increment PC
// T2    | execute step 1 (opcode now valid)
// T3    | execute step 2
// T4    | execute step 3, always the last
module control_sequencer (
   input logic                  clk,
   input logic                  rst,
   control_sequencer_if.master  bus
);

   localparam logic [23:0] CW_HLT  = 24'h000001;
   localparam logic [23:0] CW_MI   = 24'h000002;
   localparam logic [23:0] CW_RI   = 24'h000004;
   localparam logic [23:0] CW_RO   = 24'h000008;
   localparam logic [23:0] CW_IO   = 24'h000010;
   localparam logic [23:0] CW_II   = 24'h000020;
   localparam logic [23:0] CW_REGI = 24'h000040;
   localparam logic [23:0] CW_REGO = 24'h000080;
   localparam logic [23:0] CW_EO   = 24'h000100;
   localparam logic [23:0] CW_SU   = 24'h000200;
   localparam logic [23:0] CW_BI   = 24'h000400;
   localparam logic [23:0] CW_OI   = 24'h000800;
   localparam logic [23:0] CW_CE   = 24'h001000;
   localparam logic [23:0] CW_CO   = 24'h002000;
   localparam logic [23:0] CW_J    = 24'h004000;
   localparam logic [23:0] CW_FI   = 24'h008000;

   typedef enum logic [2:0] {
      S_T0 = 3'd0,
      S_T1 = 3'd1,
      S_T2 = 3'd2,
      S_T3 = 3'd3,
      S_T4 = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        halted_q, halted_d;
   logic [23:0] word;
   logic [23:0] cw;

   function automatic logic [23:0] decode(input logic [3:0] op,
                                          input logic [2:0] st,
                                          input logic [1:0] fl);
      logic [23:0] w;
      w = '0;
      case (st)
         3'd0: w = CW_CO | CW_MI;
         3'd1: w = CW_RO | CW_II | CW_CE;
         3'd2: begin
            case (op)
               4'd1, 4'd2, 4'd3, 4'd4: w = CW_IO | CW_MI;
               4'd5:  w = CW_IO | CW_REGI;
               4'd6:  w = CW_IO | CW_J;
               4'd7:  w = fl[0] ? (CW_IO | CW_J) : 24'h0;
               4'd8:  w = fl[1] ? (CW_IO | CW_J) : 24'h0;
               4'd14: w = CW_REGO | CW_OI;
               4'd15: w = CW_HLT;
               default: w = '0;
            endcase
         end
         3'd3: begin
            case (op)
               4'd1:       w = CW_RO | CW_REGI;
               4'd2, 4'd3: w = CW_RO | CW_BI;
               4'd4:       w = CW_REGO | CW_RI;
               default:    w = '0;
            endcase
         end
         3'd4: begin
            case (op)
               4'd2:    w = CW_EO | CW_REGI | CW_FI;
               4'd3:    w = CW_EO | CW_SU | CW_REGI | CW_FI;
               default: w = '0;
            endcase
         end
         default: w = '0;
      endcase
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_T0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      cw       = '0;
      word     = decode(bus.opcode, state_q, bus.flags);
      if (halted_q) begin
         state_d = S_T0;
      end else begin
         cw = word;
         if (word[0]) begin
            halted_d = 1'b1;
            state_d  = S_T0;
         end else begin
            case (state_q)
               S_T0: state_d = S_T1;
               S_T1: state_d = S_T2;
               S_T4: state_d = S_T0;
               // skip to the next fetch as soon as the following step is empty
               default: state_d = (decode(bus.opcode, state_q + 3'd1, bus.flags) == 24'h0)
                                  ? S_T0 : state_t'(state_q + 3'd1);
            endcase
         end
      end
      if (rst) cw = '0;
   end

   assign bus.control_word = cw;
   assign bus.step         = state_q;
   assign bus.halted       = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] exec_tab [16][3];
   logic [23:0] exp_w [8];
   int          exp_s [8];

   int          m_step   = 0;
   int          m_halted = 0;
   logic [23:0] m_word;
   int          m_len;
   logic        chk_en = 1'b1;
   int          hold_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Instruction-level view: fetch words are fixed, execute words come from a
   // table, conditional jumps are blanked when their flag is clear.
   function automatic logic [23:0] word_of(input logic [3:0] op, input int st, input logic [1:0] fl);
      logic [23:0] w;
      if (st == 0)      w = 24'h002002;
      else if (st == 1) w = 24'h001028;
      else if (st <= 4) w = exec_tab[op][st-2];
      else              w = 24'h0;
      if ((op == 4'd7 && !fl[0]) || (op == 4'd8 && !fl[1])) begin
         if (st >= 2) w = 24'h0;
      end
      return w;
   endfunction

   // Total cycles from T0 to the last non-empty step, never shorter than 3.
   function automatic int ins_len(input logic [3:0] op, input logic [1:0] fl);
      int n;
      n = 1;
      for (int k = 0; k < 3; k++)
         if (word_of(op, k + 2, fl) != 24'h0) n = k + 1;
      return 2 + n;
   endfunction

   initial begin
      for (int o = 0; o < 16; o++)
         for (int k = 0; k < 3; k++)
            exec_tab[o][k] = 24'h0;
      exec_tab[1]  = '{24'h000012, 24'h000048, 24'h000000};
      exec_tab[2]  = '{24'h000012, 24'h000408, 24'h008140};
      exec_tab[3]  = '{24'h000012, 24'h000408, 24'h008340};
      exec_tab[4]  = '{24'h000012, 24'h000084, 24'h000000};
      exec_tab[5]  = '{24'h000050, 24'h000000, 24'h000000};
      exec_tab[6]  = '{24'h004010, 24'h000000, 24'h000000};
      exec_tab[7]  = '{24'h004010, 24'h000000, 24'h000000};
      exec_tab[8]  = '{24'h004010, 24'h000000, 24'h000000};
      exec_tab[14] = '{24'h000880, 24'h000000, 24'h000000};
      exec_tab[15] = '{24'h000001, 24'h000000, 24'h000000};
   end

   // Per-cycle compare against the model, then advance the model to the
   // state it must hold after the coming rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         m_word = (rst || m_halted != 0) ? 24'h0 : word_of(bus.opcode, m_step, bus.flags);
         chk("model_word", 32'(bus.control_word), 32'(m_word));
         chk("model_step", 32'(bus.step), 32'(m_step));
         chk("model_halted", 32'(bus.halted), 32'(m_halted));
         chk("upper_bits_zero", 32'(bus.control_word[23:16]), 32'h0);
         if (rst) begin
            m_step = 0;
            m_halted = 0;
         end else if (m_halted != 0) begin
            m_step = 0;
         end else if (m_word[0]) begin
            m_halted = 1;
            m_step = 0;
         end else if (m_step < 2) begin
            m_step = m_step + 1;
         end else begin
            m_len  = ins_len(bus.opcode, bus.flags);
            m_step = (m_step + 1 < m_len) ? m_step + 1 : 0;
         end
      end
   end

   task automatic do_reset(input logic [3:0] op, input logic [1:0] fl);
      @(posedge clk); #1;
      rst = 1'b1;
      bus.opcode = op;
      bus.flags = fl;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_literal(input string nm, input logic [3:0] op, input logic [1:0] fl, input int n);
      do_reset(op, fl);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({nm, "_word"}, 32'(bus.control_word), 32'(exp_w[i]));
         chk({nm, "_step"}, 32'(bus.step), 32'(exp_s[i]));
      end
   endtask

   initial begin
      bus.opcode = 4'd0;
      bus.flags  = 2'b00;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_step", 32'(bus.step), 32'h0);
      chk("reset_halted", 32'(bus.halted), 32'h0);
      chk("reset_word", 32'(bus.control_word), 32'h0);

      exp_w = '{24'h002002, 24'h001028, 24'h000012, 24'h000048, 24'h002002, 24'h0, 24'h0, 24'h0};
      exp_s = '{0, 1, 2, 3, 0, 0, 0, 0};
      run_literal("lda", 4'd1, 2'b00, 5);

      exp_w = '{24'h002002, 24'h001028, 24'h000012, 24'h000408, 24'h008340, 24'h002002, 24'h0, 24'h0};
      exp_s = '{0, 1, 2, 3, 4, 0, 0, 0};
      run_literal("sub", 4'd3, 2'b00, 6);

      exp_w = '{24'h002002, 24'h001028, 24'h000000, 24'h002002, 24'h0, 24'h0, 24'h0, 24'h0};
      exp_s = '{0, 1, 2, 0, 0, 0, 0, 0};
      run_literal("jc_untaken", 4'd7, 2'b00, 4);
      run_literal("jz_untaken", 4'd8, 2'b01, 4);
      for (int o = 9; o <= 13; o++) run_literal("nop_class", 4'(o), 2'b11, 4);
      run_literal("nop", 4'd0, 2'b00, 4);

      exp_w = '{24'h002002, 24'h001028, 24'h004010, 24'h002002, 24'h0, 24'h0, 24'h0, 24'h0};
      run_literal("jc_taken", 4'd7, 2'b01, 4);
      run_literal("jz_taken", 4'd8, 2'b10, 4);

      exp_w = '{24'h002002, 24'h001028, 24'h000001, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
      exp_s = '{0, 1, 2, 0, 0, 0, 0, 0};
      run_literal("hlt", 4'd15, 2'b00, 3);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         bus.opcode = 4'($urandom_range(0, 15));
         bus.flags  = 2'($urandom);
         @(negedge clk);
         chk("halt_latched", 32'(bus.halted), 32'h1);
         chk("halt_step", 32'(bus.step), 32'h0);
         chk("halt_word", 32'(bus.control_word), 32'h0);
      end
      do_reset(4'd1, 2'b00);
      @(negedge clk);
      chk("post_halt_word", 32'(bus.control_word), 32'h002002);
      chk("post_halt_halted", 32'(bus.halted), 32'h0);

      // reset during ADD T3, held for two cycles
      do_reset(4'd2, 2'b00);
      repeat (3) @(negedge clk);
      chk("add_t2_word", 32'(bus.control_word), 32'h000012);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_t3_step", 32'(bus.step), 32'h3);
      chk("rst_t3_word", 32'(bus.control_word), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_held_step", 32'(bus.step), 32'h0);
      chk("rst_held_word", 32'(bus.control_word), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_word", 32'(bus.control_word), 32'h002002);

      // randomized run: opcode held for a few cycles, flags change freely
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (hold_cnt == 0) begin
            bus.opcode = 4'($urandom_range(0, 15));
            hold_cnt = $urandom_range(1, 6);
         end else begin
            hold_cnt--;
         end
         bus.flags = 2'($urandom);
         rst = ($urandom_range(0, 39) == 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
